// File: rtl/ir_pkg.sv
// Shared types and constants for the instruction-byte decoder: FSM states,
// opcode values and the reserved operand-length code.
package ir_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_OPND1  = 3'd1,
      ST_OPND2  = 3'd2,
      ST_EMIT   = 3'd3,
      ST_HALTED = 3'd4
   } state_e;

   localparam logic [3:0] OP_NOP      = 4'h0;
   localparam logic [3:0] OP_LOAD_TOK = 4'h1;
   localparam logic [3:0] OP_LOAD_W   = 4'h2;
   localparam logic [3:0] OP_MAC      = 4'h3;
   localparam logic [3:0] OP_SOFTMAX  = 4'h4;
   localparam logic [3:0] OP_STORE    = 4'h5;
   localparam logic [3:0] OP_HALT     = 4'hF;

   localparam logic [1:0] LEN_ILLEGAL = 2'b11;

   // True when a header byte carries a usable operand-length code.
   function automatic logic len_is_legal(input logic [7:0] hdr);
      return hdr[3:2] != LEN_ILLEGAL;
   endfunction

endpackage

// File: rtl/ir_decode_fsm.sv
// Assembles a header byte plus 0..2 operand bytes into one decoded instruction,
// presented on a valid/ready output; a HALT opcode parks the decoder until reset.
module ir_decode_fsm
   import ir_pkg::*;
#(
   parameter int         OPND_W  = 16,
   parameter logic [3:0] HALT_OP = OP_HALT
) (
   input  logic              clock,
   input  logic              rst,
   input  logic [7:0]        data_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_opcode,
   output logic [1:0]        out_dst,
   output logic [1:0]        out_len,
   output logic [OPND_W-1:0] out_operand,
   output logic              halted,
   output logic              err_illegal
);

   state_e              state_q, state_d;
   logic [3:0]          opcode_q, opcode_d;
   logic [1:0]          dst_q, dst_d;
   logic [1:0]          len_q, len_d;
   logic [OPND_W-1:0]   operand_q, operand_d;
   logic                out_valid_q, out_valid_d;
   logic                halted_q, halted_d;
   logic                err_q, err_d;
   logic                accept;

   // Gated by rst so the stream sees back-pressure for the whole reset window.
   assign in_ready = !rst && ((state_q == ST_IDLE) || (state_q == ST_OPND1) ||
                              (state_q == ST_OPND2));
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d   = state_q;
      opcode_d  = opcode_q;
      dst_d     = dst_q;
      len_d     = len_q;
      operand_d = operand_q;
      err_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (!len_is_legal(data_in)) begin
                  err_d = 1'b1;
               end else begin
                  opcode_d  = data_in[7:4];
                  len_d     = data_in[3:2];
                  dst_d     = data_in[1:0];
                  operand_d = '0;
                  state_d   = (data_in[3:2] == 2'd0) ? ST_EMIT : ST_OPND1;
               end
            end
         end
         ST_OPND1: begin
            if (accept) begin
               operand_d[7:0] = data_in;
               state_d        = (len_q == 2'd1) ? ST_EMIT : ST_OPND2;
            end
         end
         ST_OPND2: begin
            if (accept) begin
               operand_d[15:8] = data_in;
               state_d         = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (out_ready) begin
               state_d = (opcode_q == HALT_OP) ? ST_HALTED : ST_IDLE;
            end
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_IDLE;
      endcase

      out_valid_d = (state_d == ST_EMIT);
      halted_d    = (state_d == ST_HALTED);
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         opcode_q    <= '0;
         dst_q       <= '0;
         len_q       <= '0;
         operand_q   <= '0;
         out_valid_q <= 1'b0;
         halted_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         opcode_q    <= opcode_d;
         dst_q       <= dst_d;
         len_q       <= len_d;
         operand_q   <= operand_d;
         out_valid_q <= out_valid_d;
         halted_q    <= halted_d;
         err_q       <= err_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_opcode  = opcode_q;
   assign out_dst     = dst_q;
   assign out_len     = len_q;
   assign out_operand = operand_q;
   assign halted      = halted_q;
   assign err_illegal = err_q;

endmodule
